// File: rtl/multi_port_switch.sv
// Address-routed switch: each accepted input beat is steered by the top
// address bits into one of NUM_PORTS independent output FIFOs, each with
// its own valid/ready handshake, fill level and saturating beat counter.
module multi_port_switch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int PSEL      = $clog2(NUM_PORTS),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_vld,
    output logic                             in_rdy,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [NUM_PORTS-1:0]             out_vld,
    input  logic [NUM_PORTS-1:0]             out_rdy,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]  out_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_PORTS*CW-1:0]          occupancy,
    output logic [NUM_PORTS*16-1:0]          pkt_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } state_e;

    logic [PSEL-1:0]      dest;
    logic [NUM_PORTS-1:0] full;

    // Routing is decided per beat from the address alone, so a full FIFO
    // only stalls beats aimed at it.
    assign dest   = in_addr[ADDR_WIDTH-1 -: PSEL];
    assign in_rdy = !full[dest];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_e          state_q, state_d;
        logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]   occ_q, occ_d;
        logic [15:0]     cnt_q, cnt_d;
        logic [EW-1:0]   mem_q [FIFO_DEPTH];
        logic [EW-1:0]   head;
        logic            push, pop;

        assign full[p] = (occ_q == CW'(FIFO_DEPTH));
        assign push    = in_vld && in_rdy && (dest == PSEL'(p));
        assign pop     = out_vld[p] && out_rdy[p];

        // Port state registers with synchronous active-low reset.
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q  <= ST_EMPTY;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                cnt_q    <= '0;
            end else begin
                state_q  <= state_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
                cnt_q    <= cnt_d;
            end
        end

        // Next-state: EMPTY/NONEMPTY machine, pointers, fill level, counter.
        // NOTE: every output of this block gets a default first so no latch is inferred.
        always_comb begin
            state_d  = state_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            cnt_d    = cnt_q;

            case (state_q)
                ST_EMPTY:    if (push) state_d = ST_NONEMPTY;
                ST_NONEMPTY: if (pop && !push && occ_q == CW'(1)) state_d = ST_EMPTY;
                default:     state_d = ST_EMPTY;
            endcase

            // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH naturally.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase

            if (push && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end

        // Storage write; contents are only meaningful between the pointers.
        // NOTE: the memory array has no reset; resetting the pointers makes stale entries unreachable.
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= {in_addr, in_data};
        end

        assign head       = mem_q[rd_ptr_q];
        assign out_vld[p] = (state_q == ST_NONEMPTY);

        assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] =
            out_vld[p] ? head[EW-1 -: ADDR_WIDTH] : '0;
        assign out_data[p*DATA_WIDTH +: DATA_WIDTH] =
            out_vld[p] ? head[DATA_WIDTH-1:0] : '0;
        assign occupancy[p*CW +: CW] = occ_q;
        assign pkt_cnt[p*16 +: 16]   = cnt_q;
    end

endmodule

// File: doc/multi_port_switch.md
MULTI_PORT_SWITCH -- requirements
Module: multi_port_switch

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the width of the address field.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of the data field.
REQ-003 The block SHALL have parameter NUM_PORTS, default 4, meaning the output port count; legal values are 2, 4 and 8.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning entries per output FIFO; it is a power of two, 2..16.
REQ-005 The block SHALL define PSEL = log2(NUM_PORTS) and CW = log2(FIFO_DEPTH)+1.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rstn  input  1  reset, synchronous, active-low.
REQ-008 in_vld  input  1  input beat valid.
REQ-009 in_rdy  output  1  input beat accepted when in_vld and in_rdy are both high.
REQ-010 in_addr  input  ADDR_WIDTH  beat address; the top PSEL bits select the destination port.
REQ-011 in_data  input  DATA_WIDTH  beat payload.
REQ-012 out_vld  output  NUM_PORTS  per-port head-valid.
REQ-013 out_rdy  input  NUM_PORTS  per-port consumer ready.
REQ-014 out_addr  output  NUM_PORTS*ADDR_WIDTH  per-port head address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 out_data  output  NUM_PORTS*DATA_WIDTH  per-port head data, sliced the same way as out_addr.
REQ-016 occupancy  output  NUM_PORTS*CW  per-port FIFO fill level.
REQ-017 pkt_cnt  output  NUM_PORTS*16  per-port count of accepted beats.

Function
REQ-018 The destination port SHALL be dest = in_addr[ADDR_WIDTH-1 -: PSEL], decoded combinationally.
REQ-019 in_rdy SHALL equal !full[dest]; it is a combinational function of in_addr and FIFO state only, not of in_vld.
REQ-020 An accepted beat SHALL be written to the tail of FIFO[dest] as the full unmodified {in_addr, in_data}; no other FIFO is written.
REQ-021 out_vld[p] SHALL be high exactly when occupancy[p] != 0; out_addr and out_data for port p SHALL show the FIFO[p] head entry.
REQ-022 When FIFO[p] is empty, its out_addr and out_data slices SHALL be driven to 0.
REQ-023 A pop SHALL occur on port p when out_vld[p] and out_rdy[p] are both high; the next entry appears on the following cycle.
REQ-024 Latency SHALL be exactly 1 cycle: a beat accepted in cycle N appears at its port's head in cycle N+1 if that FIFO was empty.
REQ-025 Simultaneous push and pop on the same port SHALL leave occupancy unchanged and preserve FIFO order.
REQ-026 When a FIFO is full, in_rdy SHALL be low for beats targeting it, even if a pop occurs on that port in the same cycle.
REQ-027 A full FIFO SHALL NOT block beats to other ports: the routing decision is made per beat.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy ranges 0..FIFO_DEPTH.
REQ-029 pkt_cnt[p] SHALL increment by 1 on each accepted beat to port p and saturate at 16'hFFFF.
REQ-030 Each port SHALL run an independent 2-state machine, EMPTY or NONEMPTY: push moves EMPTY to NONEMPTY; a pop of the last entry without a simultaneous push moves NONEMPTY to EMPTY.
REQ-031 out_rdy[p] asserted while out_vld[p] is low SHALL have no effect.

Reset
REQ-032 While rstn is low at a clock edge, every pointer, occupancy and pkt_cnt SHALL clear to 0 and every state machine SHALL enter EMPTY; out_vld, out_addr and out_data are then all 0.
REQ-033 A reset mid-operation SHALL discard all buffered beats; a beat presented in the reset cycle SHALL NOT be stored or counted.
REQ-034 FIFO storage arrays SHALL NOT require reset.

Verification
REQ-035 Defaults; after reset, drive in_vld=1, in_addr=8'h05, in_data=16'hAAAA for one cycle -> next cycle out_vld=4'b0001, port0 out_addr=8'h05, out_data=16'hAAAA, pkt_cnt[0]=1.
REQ-036 Hold out_rdy[2]=0; send 4 beats with addr 8'h80..8'h83 -> occupancy[2]=4 and in_rdy=0 for addr 8'h8x; a beat to 8'hC0 is accepted in the same cycle.
REQ-037 FIFO[1] full with out_rdy[1]=1; present a beat to addr 8'h40 -> in_rdy=0; the next cycle occupancy[1]=3 and the beat is accepted.
REQ-038 Occupancy 2 on port 3, with a push and a pop in the same cycle -> occupancy stays 2 and the pop order matches the push order across pointer wrap.
REQ-039 Assert rstn=0 with 3 beats buffered on port 0 and in_vld=1 -> the next cycle out_vld=0, occupancy all 0, pkt_cnt all 0.
REQ-040 Force pkt_cnt[0] near 16'hFFFF via 2 extra beats -> the count holds at 16'hFFFF.
